boot_loader: RTL and testbench

Synthesizable program loader that replaces hand-sequenced bench stimulus for filling CPU memory. It accepts a framed word stream over a valid/ready handshake and writes the payload into program RAM through the shared address/data buses while holding the CPU in HALT. It verifies a checksum, then releases HALT and tristates its bus drivers. It sits between the host/UART stream source and the RAM/CPU bus.

---
 rtl/boot_loader.sv | 144 ++++++++++++++
 tb/tb_boot_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Framed-stream program loader: holds the CPU in HALT, writes the payload into
// program RAM over the shared buses, verifies the checksum, then releases the bus.
module boot_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  IN_READY,
  output logic                  RAM_EN,
  output logic                  RAM_RW,
  output logic [ADDR_WIDTH-1:0] ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  BUS_DRIVE,
  output logic                  HALT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_WRITE, S_CHECK, S_RUN, S_ERR
  } state_e;

  state_e                state_q;
  logic                  in_ready_q, ram_en_q, ram_rw_q, bus_drive_q;
  logic                  halt_q, busy_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0] addr_q, base_q;
  logic [DATA_WIDTH-1:0] data_q, cnt_q, idx_q, sum_q;

  logic                  accept;
  logic [DATA_WIDTH-1:0] idx_d, sum_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;

  assign accept    = IN_VALID & in_ready_q;
  assign idx_d     = idx_q + DATA_WIDTH'(1);
  assign sum_d     = sum_q + IN_DATA;
  // The index is DATA_WIDTH wide; resize it so the address wraps at ADDR_WIDTH.
  assign wr_addr_d = base_q + ADDR_WIDTH'(idx_q);

  // NOTE: every state bit lives in this one clocked block and is assigned with
  // non-blocking '<=' so all registers update together from pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      bus_drive_q <= 1'b0;
      halt_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
    end else begin
      ram_en_q <= 1'b0;
      ram_rw_q <= 1'b1;

      case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          if (START) begin
            state_q     <= S_HDR_ADDR;
            in_ready_q  <= 1'b1;
            halt_q      <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            bus_drive_q <= 1'b1;
            sum_q       <= '0;
            idx_q       <= '0;
          end
        end

        S_HDR_ADDR: begin
          if (accept) begin
            base_q  <= ADDR_WIDTH'(IN_DATA);
            state_q <= S_HDR_CNT;
          end
        end

        S_HDR_CNT: begin
          if (accept) begin
            cnt_q   <= IN_DATA;
            state_q <= (IN_DATA == '0) ? S_CHECK : S_WRITE;
          end
        end

        S_WRITE: begin
          if (accept) begin
            ram_en_q <= 1'b1;
            ram_rw_q <= 1'b0;
            addr_q   <= wr_addr_d;
            data_q   <= IN_DATA;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            // Comparing the incremented index lets N = 2^DATA_WIDTH-1 finish without overflow.
            if (idx_d == cnt_q) state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (accept) begin
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            bus_drive_q <= 1'b0;
            if (IN_DATA == sum_q) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
              halt_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY    = in_ready_q;
  assign RAM_EN      = ram_en_q;
  assign RAM_RW      = ram_rw_q;
  assign ADDRESS_OUT = addr_q;
  assign DATA_OUT    = data_q;
  assign BUS_DRIVE   = bus_drive_q;
  assign HALT        = halt_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a table of frames driven through the stream port, with
// expected RAM writes queued at accept time and matched against every RAM strobe.
module tb_boot_loader;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic          IN_READY, RAM_EN, RAM_RW, BUS_DRIVE, HALT, BUSY, DONE, ERROR;
  logic [AW-1:0] ADDRESS_OUT;
  logic [DW-1:0] DATA_OUT;

  boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .RAM_EN(RAM_EN), .RAM_RW(RAM_RW), .ADDRESS_OUT(ADDRESS_OUT), .DATA_OUT(DATA_OUT),
    .BUS_DRIVE(BUS_DRIVE), .HALT(HALT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    logic [AW-1:0]      base;
    logic [DW-1:0]      n;
    logic [4:0][DW-1:0] pay;
    logic [4:0][1:0]    gaps;
    bit                 start_mid;
    logic [DW-1:0]      csum;
    bit                 exp_done;
  } frame_t;

  frame_t frames[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every RAM strobe must match the oldest queued write, in the cycle right after its accept.
  always @(negedge CLK) begin
    wr_t e;
    if (RESET === 1'b1) begin
      if (RAM_EN === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write pending (t=%0t)",
                   ADDRESS_OUT, DATA_OUT, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(ADDRESS_OUT), 32'(e.addr));
          check("wr_data", 32'(DATA_OUT), 32'(e.data));
          check("wr_cycle", cyc, e.cyc);
          check("wr_rw", 32'(RAM_RW), 32'd0);
          check("wr_drive", 32'(BUS_DRIVE), 32'd1);
        end
      end else begin
        check("idle_rw", 32'(RAM_RW), 32'd1);
      end
    end
  end

  task automatic set_frame(input int idx, input logic [AW-1:0] base, input logic [DW-1:0] n,
                           input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                           input logic [DW-1:0] p2, input logic [1:0] g1, input logic [1:0] g2,
                           input bit start_mid, input logic [DW-1:0] csum, input bit exp_done);
    frames[idx].base      = base;
    frames[idx].n         = n;
    frames[idx].pay       = '0;
    frames[idx].pay[0]    = p0;
    frames[idx].pay[1]    = p1;
    frames[idx].pay[2]    = p2;
    frames[idx].gaps      = '0;
    frames[idx].gaps[1]   = g1;
    frames[idx].gaps[2]   = g2;
    frames[idx].start_mid = start_mid;
    frames[idx].csum      = csum;
    frames[idx].exp_done  = exp_done;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_halt"},  32'(HALT), 32'd1);
    check({tag, "_rdy"},   32'(IN_READY), 32'd0);
    check({tag, "_en"},    32'(RAM_EN), 32'd0);
    check({tag, "_rw"},    32'(RAM_RW), 32'd1);
    check({tag, "_drive"}, 32'(BUS_DRIVE), 32'd0);
    check({tag, "_addr"},  32'(ADDRESS_OUT), 32'd0);
    check({tag, "_data"},  32'(DATA_OUT), 32'd0);
    check({tag, "_busy"},  32'(BUSY), 32'd0);
    check({tag, "_done"},  32'(DONE), 32'd0);
    check({tag, "_error"}, 32'(ERROR), 32'd0);
  endtask

  task automatic do_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("start_halt",  32'(HALT), 32'd1);
    check("start_busy",  32'(BUSY), 32'd1);
    check("start_drive", 32'(BUS_DRIVE), 32'd1);
    check("start_done",  32'(DONE), 32'd0);
    check("start_error", 32'(ERROR), 32'd0);
    check("start_rdy",   32'(IN_READY), 32'd1);
  endtask

  // Called one time unit after an edge; holds IN_VALID until the word is taken.
  task automatic send_word(input logic [DW-1:0] w, input bit is_payload, input logic [AW-1:0] addr);
    bit rdy;
    bit acc;
    acc      = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = w;
    for (int t = 0; t < 20; t++) begin
      rdy = IN_READY;
      @(posedge CLK); #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    IN_VALID = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: word 0x%0h not taken within 20 cycles", w);
    end else if (is_payload) begin
      exp_q.push_back('{addr: addr, data: w, cyc: cyc});
    end
  endtask

  task automatic run_frame(input frame_t f);
    do_start();
    send_word(16'(f.base), 1'b0, '0);
    send_word(f.n, 1'b0, '0);
    for (int i = 0; i < int'(f.n); i++) begin
      for (int g = 0; g < int'(f.gaps[i]); g++) begin
        if (f.start_mid && g == 0) START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("gap_busy", 32'(BUSY), 32'd1);
        check("gap_rdy",  32'(IN_READY), 32'd1);
      end
      send_word(f.pay[i], 1'b1, f.base + AW'(i));
    end
    send_word(f.csum, 1'b0, '0);
    check("end_done",  32'(DONE), 32'(f.exp_done));
    check("end_error", 32'(ERROR), 32'(!f.exp_done));
    check("end_halt",  32'(HALT), 32'(!f.exp_done));
    check("end_busy",  32'(BUSY), 32'd0);
    check("end_drive", 32'(BUS_DRIVE), 32'd0);
    check("end_rdy",   32'(IN_READY), 32'd0);
    check("end_en",    32'(RAM_EN), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_frame(0, 16'h0010, 16'd3, 16'h0000, 16'h0001, 16'h0005, 2'd0, 2'd0, 1'b0, 16'h0006, 1'b1);
    set_frame(1, 16'h0010, 16'd3, 16'h0000, 16'h0001, 16'h0005, 2'd0, 2'd0, 1'b0, 16'h0007, 1'b0);
    set_frame(2, 16'hFFFF, 16'd2, 16'h7F98, 16'h0010, 16'h0000, 2'd0, 2'd0, 1'b0, 16'h7FA8, 1'b1);
    set_frame(3, 16'h0040, 16'd0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b1);
    set_frame(4, 16'h0200, 16'd3, 16'h1111, 16'h2222, 16'h3333, 2'd2, 2'd1, 1'b1, 16'h6666, 1'b1);

    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("idle_rdy",  32'(IN_READY), 32'd0);
    check("idle_halt", 32'(HALT), 32'd1);

    for (int i = 0; i < 5; i++) run_frame(frames[i]);

    // Stream words offered in RUN must not be consumed nor disturb the CPU.
    IN_VALID = 1'b1;
    IN_DATA  = 16'h1234;
    repeat (3) begin
      @(posedge CLK); #1;
      check("run_rdy",  32'(IN_READY), 32'd0);
      check("run_done", 32'(DONE), 32'd1);
      check("run_halt", 32'(HALT), 32'd0);
    end
    IN_VALID = 1'b0;

    // Reset in the middle of a 5-word payload, after two writes.
    do_start();
    send_word(16'h0300, 1'b0, '0);
    send_word(16'd5, 1'b0, '0);
    send_word(16'hAAAA, 1'b1, 16'h0300);
    send_word(16'hBBBB, 1'b1, 16'h0301);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_pending", exp_q.size(), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    run_frame(frames[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
